// File: rtl/axil_demux_pkg.sv
// Shared types, response codes and address-decode helpers for the AXI4-Lite peripheral demux.
package axil_demux_pkg;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAITB, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAITR, R_RESP} rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Addresses are zero-extended to 64 bits so one helper serves every address width.
  function automatic logic addr_hit(input logic [63:0] addr, input logic [63:0] base,
                                    input int unsigned hi_lsb);
    return ((addr ^ base) >> hi_lsb) == 64'd0;
  endfunction

  function automatic logic [31:0] addr_idx(input logic [63:0] addr, input int unsigned lsb,
                                           input int unsigned idx_w);
    return 32'((addr >> lsb) & ((64'd1 << idx_w) - 64'd1));
  endfunction

endpackage

// File: rtl/axil_demux_wdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module axil_demux_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axil_periph_demux.sv
// 1-to-SLAVE_NUM AXI4-Lite demux with local DECERR for unmapped addresses and watchdog SLVERR recovery.
module axil_periph_demux
  import axil_demux_pkg::*;
#(
  parameter int unsigned                 SLAVE_NUM        = 3,
  parameter int unsigned                 AXIL_ADDR_WIDTH  = 32,
  parameter int unsigned                 AXIL_DATA_WIDTH  = 32,
  parameter int unsigned                 SLAVE_ADDR_WIDTH = 12,
  parameter logic [AXIL_ADDR_WIDTH-1:0]  BASE_ADDR        = 32'h4000_0000,
  parameter int unsigned                 TIMEOUT_CYCLES   = 1024
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  // upstream
  input  logic [AXIL_ADDR_WIDTH-1:0]                        s_axil_awaddr_i,
  input  logic                                              s_axil_awvalid_i,
  output logic                                              s_axil_awready_o,
  input  logic [AXIL_DATA_WIDTH-1:0]                        s_axil_wdata_i,
  input  logic [AXIL_DATA_WIDTH/8-1:0]                      s_axil_wstrb_i,
  input  logic                                              s_axil_wvalid_i,
  output logic                                              s_axil_wready_o,
  output logic [1:0]                                        s_axil_bresp_o,
  output logic                                              s_axil_bvalid_o,
  input  logic                                              s_axil_bready_i,
  input  logic [AXIL_ADDR_WIDTH-1:0]                        s_axil_araddr_i,
  input  logic                                              s_axil_arvalid_i,
  output logic                                              s_axil_arready_o,
  output logic [AXIL_DATA_WIDTH-1:0]                        s_axil_rdata_o,
  output logic [1:0]                                        s_axil_rresp_o,
  output logic                                              s_axil_rvalid_o,
  input  logic                                              s_axil_rready_i,
  // downstream, index i = window i
  output logic [SLAVE_NUM-1:0][AXIL_ADDR_WIDTH-1:0]         m_axil_awaddr_o,
  output logic [SLAVE_NUM-1:0]                              m_axil_awvalid_o,
  input  logic [SLAVE_NUM-1:0]                              m_axil_awready_i,
  output logic [SLAVE_NUM-1:0][AXIL_DATA_WIDTH-1:0]         m_axil_wdata_o,
  output logic [SLAVE_NUM-1:0][AXIL_DATA_WIDTH/8-1:0]       m_axil_wstrb_o,
  output logic [SLAVE_NUM-1:0]                              m_axil_wvalid_o,
  input  logic [SLAVE_NUM-1:0]                              m_axil_wready_i,
  input  logic [SLAVE_NUM-1:0][1:0]                         m_axil_bresp_i,
  input  logic [SLAVE_NUM-1:0]                              m_axil_bvalid_i,
  output logic [SLAVE_NUM-1:0]                              m_axil_bready_o,
  output logic [SLAVE_NUM-1:0][AXIL_ADDR_WIDTH-1:0]         m_axil_araddr_o,
  output logic [SLAVE_NUM-1:0]                              m_axil_arvalid_o,
  input  logic [SLAVE_NUM-1:0]                              m_axil_arready_i,
  input  logic [SLAVE_NUM-1:0][AXIL_DATA_WIDTH-1:0]         m_axil_rdata_i,
  input  logic [SLAVE_NUM-1:0][1:0]                         m_axil_rresp_i,
  input  logic [SLAVE_NUM-1:0]                              m_axil_rvalid_i,
  output logic [SLAVE_NUM-1:0]                              m_axil_rready_o,
  output logic                                              dec_err_o,
  output logic                                              timeout_o
);

  localparam int unsigned IDX_W  = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int unsigned HI_LSB = SLAVE_ADDR_WIDTH + IDX_W;

  // decode
  logic                 aw_hit, ar_hit;
  logic [IDX_W-1:0]     aw_idx, ar_idx;
  logic [SLAVE_NUM-1:0] aw_onehot, ar_onehot;

  always_comb begin
    aw_idx    = IDX_W'(addr_idx(64'(s_axil_awaddr_i), SLAVE_ADDR_WIDTH, IDX_W));
    ar_idx    = IDX_W'(addr_idx(64'(s_axil_araddr_i), SLAVE_ADDR_WIDTH, IDX_W));
    aw_hit    = addr_hit(64'(s_axil_awaddr_i), 64'(BASE_ADDR), HI_LSB) && (32'(aw_idx) < SLAVE_NUM);
    ar_hit    = addr_hit(64'(s_axil_araddr_i), 64'(BASE_ADDR), HI_LSB) && (32'(ar_idx) < SLAVE_NUM);
    aw_onehot = SLAVE_NUM'(1) << aw_idx;
    ar_onehot = SLAVE_NUM'(1) << ar_idx;
  end

  // write path state
  wr_state_e                    wr_state_q;
  logic [IDX_W-1:0]             w_idx_q;
  logic [AXIL_ADDR_WIDTH-1:0]   awaddr_q;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q;
  logic [AXIL_DATA_WIDTH/8-1:0] wstrb_q;
  logic [SLAVE_NUM-1:0]         awvalid_q, wvalid_q;
  logic [1:0]                   bresp_q;
  logic                         w_dec_q, w_to_q;
  logic                         w_expire, aw_done, w_done;

  // read path state
  rd_state_e                    rd_state_q;
  logic [IDX_W-1:0]             r_idx_q;
  logic [AXIL_ADDR_WIDTH-1:0]   araddr_q;
  logic [AXIL_DATA_WIDTH-1:0]   rdata_q;
  logic [SLAVE_NUM-1:0]         arvalid_q;
  logic [1:0]                   rresp_q;
  logic                         r_dec_q, r_to_q;
  logic                         r_expire;

  axil_demux_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog_wr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (wr_state_q == W_IDLE),
    .enable_i ((wr_state_q == W_FWD) || (wr_state_q == W_WAITB)),
    .expire_o (w_expire)
  );

  axil_demux_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog_rd (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (rd_state_q == R_IDLE),
    .enable_i ((rd_state_q == R_FWD) || (rd_state_q == R_WAITR)),
    .expire_o (r_expire)
  );

  assign aw_done = !awvalid_q[w_idx_q] || m_axil_awready_i[w_idx_q];
  assign w_done  = !wvalid_q[w_idx_q]  || m_axil_wready_i[w_idx_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      w_idx_q    <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= '0;
      wvalid_q   <= '0;
      bresp_q    <= RESP_OKAY;
      w_dec_q    <= 1'b0;
      w_to_q     <= 1'b0;
    end else begin
      w_dec_q <= 1'b0;
      w_to_q  <= 1'b0;
      unique case (wr_state_q)
        W_IDLE: begin
          if (s_axil_awvalid_i && s_axil_wvalid_i) begin
            awaddr_q <= s_axil_awaddr_i;
            wdata_q  <= s_axil_wdata_i;
            wstrb_q  <= s_axil_wstrb_i;
            w_idx_q  <= aw_idx;
            if (aw_hit) begin
              awvalid_q  <= aw_onehot;
              wvalid_q   <= aw_onehot;
              wr_state_q <= W_FWD;
            end else begin
              bresp_q    <= RESP_DECERR;
              w_dec_q    <= 1'b1;
              wr_state_q <= W_RESP;
            end
          end
        end
        W_FWD: begin
          if (w_expire) begin
            awvalid_q  <= '0;
            wvalid_q   <= '0;
            bresp_q    <= RESP_SLVERR;
            w_to_q     <= 1'b1;
            wr_state_q <= W_RESP;
          end else begin
            if (m_axil_awready_i[w_idx_q]) awvalid_q <= '0;
            if (m_axil_wready_i[w_idx_q])  wvalid_q  <= '0;
            if (aw_done && w_done)         wr_state_q <= W_WAITB;
          end
        end
        W_WAITB: begin
          if (w_expire) begin
            bresp_q    <= RESP_SLVERR;
            w_to_q     <= 1'b1;
            wr_state_q <= W_RESP;
          end else if (m_axil_bvalid_i[w_idx_q]) begin
            bresp_q    <= m_axil_bresp_i[w_idx_q];
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axil_bready_i) wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      r_idx_q    <= '0;
      araddr_q   <= '0;
      rdata_q    <= '0;
      arvalid_q  <= '0;
      rresp_q    <= RESP_OKAY;
      r_dec_q    <= 1'b0;
      r_to_q     <= 1'b0;
    end else begin
      r_dec_q <= 1'b0;
      r_to_q  <= 1'b0;
      unique case (rd_state_q)
        R_IDLE: begin
          if (s_axil_arvalid_i) begin
            araddr_q <= s_axil_araddr_i;
            r_idx_q  <= ar_idx;
            if (ar_hit) begin
              arvalid_q  <= ar_onehot;
              rd_state_q <= R_FWD;
            end else begin
              rresp_q    <= RESP_DECERR;
              rdata_q    <= '0;
              r_dec_q    <= 1'b1;
              rd_state_q <= R_RESP;
            end
          end
        end
        R_FWD: begin
          if (r_expire) begin
            arvalid_q  <= '0;
            rresp_q    <= RESP_SLVERR;
            rdata_q    <= '0;
            r_to_q     <= 1'b1;
            rd_state_q <= R_RESP;
          end else if (m_axil_arready_i[r_idx_q]) begin
            arvalid_q  <= '0;
            rd_state_q <= R_WAITR;
          end
        end
        R_WAITR: begin
          if (r_expire) begin
            rresp_q    <= RESP_SLVERR;
            rdata_q    <= '0;
            r_to_q     <= 1'b1;
            rd_state_q <= R_RESP;
          end else if (m_axil_rvalid_i[r_idx_q]) begin
            rresp_q    <= m_axil_rresp_i[r_idx_q];
            rdata_q    <= m_axil_rdata_i[r_idx_q];
            rd_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axil_rready_i) rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Readys are gated with rst_i so nothing is accepted while reset is held.
  assign s_axil_awready_o = !rst_i && (wr_state_q == W_IDLE) && s_axil_awvalid_i && s_axil_wvalid_i;
  assign s_axil_wready_o  = s_axil_awready_o;
  assign s_axil_bvalid_o  = (wr_state_q == W_RESP);
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_arready_o = !rst_i && (rd_state_q == R_IDLE);
  assign s_axil_rvalid_o  = (rd_state_q == R_RESP);
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;

  assign m_axil_awaddr_o  = {SLAVE_NUM{awaddr_q}};
  assign m_axil_wdata_o   = {SLAVE_NUM{wdata_q}};
  assign m_axil_wstrb_o   = {SLAVE_NUM{wstrb_q}};
  assign m_axil_araddr_o  = {SLAVE_NUM{araddr_q}};
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_arvalid_o = arvalid_q;

  // In IDLE every slave is drained so a late response from a timed-out slave cannot linger.
  always_comb begin
    m_axil_bready_o = '0;
    m_axil_rready_o = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      m_axil_bready_o[i] = !rst_i && ((wr_state_q == W_IDLE) ||
                           ((wr_state_q == W_WAITB) && (w_idx_q == IDX_W'(i))));
      m_axil_rready_o[i] = !rst_i && ((rd_state_q == R_IDLE) ||
                           ((rd_state_q == R_WAITR) && (r_idx_q == IDX_W'(i))));
    end
  end

  assign dec_err_o = w_dec_q || r_dec_q;
  assign timeout_o = w_to_q || r_to_q;

endmodule

// File: tb/tb_axil_periph_demux.sv
// Directed bench for axil_periph_demux with three behavioural AXI4-Lite slave models.
module tb_axil_periph_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]       s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]        s_wstrb = '0;
  logic              s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
  logic              s_arvalid = 1'b0, s_rready = 1'b0;
  logic              s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]        s_bresp, s_rresp;
  logic [31:0]       s_rdata;

  logic [2:0][31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0][3:0]   m_wstrb;
  logic [2:0][1:0]   m_bresp, m_rresp;
  logic [2:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [2:0]        m_arvalid, m_arready, m_rvalid, m_rready;
  logic              dec_err, tmo;

  logic [2:0]        b_hang = '0;
  logic [2:0]        ar_stall = '0;
  int                r_wait [3] = '{0, 0, 0};
  logic [31:0]       r_data [3] = '{32'h0, 32'h0, 32'h0};

  int total = 0;
  int bad   = 0;
  int dec_cnt = 0;
  int to_cnt  = 0;

  axil_periph_demux #(
    .SLAVE_NUM        (3),
    .AXIL_ADDR_WIDTH  (32),
    .AXIL_DATA_WIDTH  (32),
    .SLAVE_ADDR_WIDTH (12),
    .BASE_ADDR        (32'h4000_0000),
    .TIMEOUT_CYCLES   (1024)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .s_axil_awaddr_i  (s_awaddr),
    .s_axil_awvalid_i (s_awvalid),
    .s_axil_awready_o (s_awready),
    .s_axil_wdata_i   (s_wdata),
    .s_axil_wstrb_i   (s_wstrb),
    .s_axil_wvalid_i  (s_wvalid),
    .s_axil_wready_o  (s_wready),
    .s_axil_bresp_o   (s_bresp),
    .s_axil_bvalid_o  (s_bvalid),
    .s_axil_bready_i  (s_bready),
    .s_axil_araddr_i  (s_araddr),
    .s_axil_arvalid_i (s_arvalid),
    .s_axil_arready_o (s_arready),
    .s_axil_rdata_o   (s_rdata),
    .s_axil_rresp_o   (s_rresp),
    .s_axil_rvalid_o  (s_rvalid),
    .s_axil_rready_i  (s_rready),
    .m_axil_awaddr_o  (m_awaddr),
    .m_axil_awvalid_o (m_awvalid),
    .m_axil_awready_i (m_awready),
    .m_axil_wdata_o   (m_wdata),
    .m_axil_wstrb_o   (m_wstrb),
    .m_axil_wvalid_o  (m_wvalid),
    .m_axil_wready_i  (m_wready),
    .m_axil_bresp_i   (m_bresp),
    .m_axil_bvalid_i  (m_bvalid),
    .m_axil_bready_o  (m_bready),
    .m_axil_araddr_o  (m_araddr),
    .m_axil_arvalid_o (m_arvalid),
    .m_axil_arready_i (m_arready),
    .m_axil_rdata_i   (m_rdata),
    .m_axil_rresp_i   (m_rresp),
    .m_axil_rvalid_i  (m_rvalid),
    .m_axil_rready_o  (m_rready),
    .dec_err_o        (dec_err),
    .timeout_o        (tmo)
  );

  // Slave models: always-ready aw/w, bvalid right after both beats unless hung, rvalid after r_wait cycles.
  for (genvar g = 0; g < 3; g++) begin : g_slv
    logic        bv, rv, got_aw, got_w, rbusy;
    logic [31:0] rd, last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    int          rcnt, aw_cnt, w_cnt, ar_cnt, b_cnt;
    logic        aw_now, w_now, ar_now;

    assign aw_now       = m_awvalid[g] && m_awready[g];
    assign w_now        = m_wvalid[g] && m_wready[g];
    assign ar_now       = m_arvalid[g] && m_arready[g];
    assign m_awready[g] = 1'b1;
    assign m_wready[g]  = 1'b1;
    assign m_arready[g] = !ar_stall[g];
    assign m_bvalid[g]  = bv;
    assign m_bresp[g]   = 2'b00;
    assign m_rvalid[g]  = rv;
    assign m_rresp[g]   = 2'b00;
    assign m_rdata[g]   = rd;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        bv <= 1'b0; rv <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; rbusy <= 1'b0;
        rd <= '0; rcnt <= 0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0;
        last_awaddr <= '0; last_wdata <= '0; last_wstrb <= '0;
      end else begin
        if (aw_now) begin aw_cnt <= aw_cnt + 1; last_awaddr <= m_awaddr[g]; end
        if (w_now)  begin w_cnt <= w_cnt + 1; last_wdata <= m_wdata[g]; last_wstrb <= m_wstrb[g]; end
        if (bv && m_bready[g]) begin
          bv <= 1'b0;
          b_cnt <= b_cnt + 1;
        end else if (!bv && !b_hang[g] && (got_aw || aw_now) && (got_w || w_now)) begin
          bv <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
        end else begin
          if (aw_now) got_aw <= 1'b1;
          if (w_now)  got_w  <= 1'b1;
        end
        if (rv && m_rready[g]) rv <= 1'b0;
        if (ar_now) begin
          ar_cnt <= ar_cnt + 1;
          if (r_wait[g] == 0) begin rv <= 1'b1; rd <= r_data[g]; end
          else begin rbusy <= 1'b1; rcnt <= r_wait[g]; end
        end else if (rbusy) begin
          rcnt <= rcnt - 1;
          if (rcnt == 1) begin rv <= 1'b1; rd <= r_data[g]; rbusy <= 1'b0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dec_err) dec_cnt++;
    if (tmo)     to_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write; lat counts cycles from the accept cycle to the first bvalid cycle (T+n -> n).
  task automatic axw(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input int hold, output int lat, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    #1;
    while (!(s_awready && s_wready) && n < 50) begin @(negedge clk); #1; n++; end
    check_eq("aw_accept", 64'(s_awready && s_wready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    lat = 1;
    while (!s_bvalid && lat < 2000) begin @(negedge clk); lat++; end
    resp = s_bresp;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("b_stable", {62'd0, s_bvalid, s_bresp}, {62'd0, 1'b1, resp});
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic axr(input logic [31:0] addr, input int hold, output int lat,
                     output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b0;
    #1;
    while (!s_arready && n < 50) begin @(negedge clk); #1; n++; end
    check_eq("ar_accept", 64'(s_arready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 2000) begin @(negedge clk); lat++; end
    resp = s_rresp;
    data = s_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("r_stable", {29'd0, s_rvalid, s_rresp, s_rdata}, {29'd0, 1'b1, resp, data});
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  initial begin
    int          lw, lr, d0, t0, b0, sum0;
    logic [1:0]  rw, rr;
    logic [31:0] dr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_arready", 64'(s_arready), 64'd0);
    check_eq("rst_svalid",  64'({s_bvalid, s_rvalid}), 64'd0);
    check_eq("rst_mvalid",  64'({m_awvalid, m_wvalid, m_arvalid}), 64'd0);
    check_eq("rst_mready",  64'({m_bready, m_rready}), 64'd0);
    check_eq("rst_pulses",  64'({dec_err, tmo}), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_arready", 64'(s_arready), 64'd1);
    check_eq("rel_drain",   64'({m_bready, m_rready}), 64'h3f);

    // write hit, slave 1, zero-wait
    axw(32'h4000_1004, 32'hA5A5_A5A5, 4'hF, 0, lw, rw);
    check_eq("w1_lat",   64'(lw), 64'd3);
    check_eq("w1_resp",  64'(rw), 64'd0);
    check_eq("w1_s1cnt", 64'({g_slv[1].aw_cnt[7:0], g_slv[1].w_cnt[7:0]}), 64'h0101);
    check_eq("w1_addr",  64'(g_slv[1].last_awaddr), 64'h4000_1004);
    check_eq("w1_data",  64'(g_slv[1].last_wdata), 64'hA5A5_A5A5);
    check_eq("w1_strb",  64'(g_slv[1].last_wstrb), 64'hF);
    check_eq("w1_others", 64'(g_slv[0].aw_cnt + g_slv[2].aw_cnt + g_slv[0].w_cnt + g_slv[2].w_cnt), 64'd0);

    // read hit, slave 2, five wait cycles
    r_data[2] = 32'h1234_5678; r_wait[2] = 5;
    axr(32'h4000_2000, 0, lr, dr, rr);
    check_eq("r1_lat",    64'(lr), 64'd8);
    check_eq("r1_data",   64'(dr), 64'h1234_5678);
    check_eq("r1_resp",   64'(rr), 64'd0);
    check_eq("r1_s2cnt",  64'(g_slv[2].ar_cnt), 64'd1);
    check_eq("r1_others", 64'(g_slv[0].ar_cnt + g_slv[1].ar_cnt), 64'd0);

    // unmapped accesses
    d0 = dec_cnt;
    sum0 = g_slv[0].aw_cnt + g_slv[1].aw_cnt + g_slv[2].aw_cnt + g_slv[0].ar_cnt + g_slv[1].ar_cnt + g_slv[2].ar_cnt;
    axr(32'h4000_3000, 0, lr, dr, rr);
    check_eq("rmiss_lat",  64'(lr), 64'd1);
    check_eq("rmiss_resp", 64'(rr), 64'd3);
    check_eq("rmiss_data", 64'(dr), 64'd0);
    axw(32'h5000_0000, 32'h0BAD_0BAD, 4'hF, 0, lw, rw);
    check_eq("wmiss_lat",  64'(lw), 64'd1);
    check_eq("wmiss_resp", 64'(rw), 64'd3);
    check_eq("miss_pulses", 64'(dec_cnt - d0), 64'd2);
    check_eq("miss_quiet", 64'(g_slv[0].aw_cnt + g_slv[1].aw_cnt + g_slv[2].aw_cnt +
                              g_slv[0].ar_cnt + g_slv[1].ar_cnt + g_slv[2].ar_cnt), 64'(sum0));

    // hung slave 0 on B: watchdog expiry, late response drained, next write fine
    b_hang[0] = 1'b1;
    t0 = to_cnt;
    b0 = g_slv[0].b_cnt;
    axw(32'h4000_0010, 32'h0000_0001, 4'h1, 0, lw, rw);
    check_eq("to_lat",   64'(lw), 64'd1025);
    check_eq("to_resp",  64'(rw), 64'd2);
    check_eq("to_pulse", 64'(to_cnt - t0), 64'd1);
    b_hang[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("to_drained", 64'({31'd0, g_slv[0].bv}), 64'd0);
    check_eq("to_bcnt",    64'(g_slv[0].b_cnt - b0), 64'd1);
    axw(32'h4000_0020, 32'h0000_0011, 4'hF, 0, lw, rw);
    check_eq("post_to_lat",  64'(lw), 64'd3);
    check_eq("post_to_resp", 64'(rw), 64'd0);

    // concurrent write slave 0 and read slave 1, master back-pressure for 3 cycles
    r_data[1] = 32'hCAFE_F00D; r_wait[1] = 0;
    fork
      axw(32'h4000_0040, 32'hDEAD_BEEF, 4'hF, 3, lw, rw);
      axr(32'h4000_1080, 3, lr, dr, rr);
    join
    check_eq("cc_wlat",  64'(lw), 64'd3);
    check_eq("cc_wresp", 64'(rw), 64'd0);
    check_eq("cc_rlat",  64'(lr), 64'd3);
    check_eq("cc_rdata", 64'(dr), 64'hCAFE_F00D);
    check_eq("cc_wdata", 64'(g_slv[0].last_wdata), 64'hDEAD_BEEF);

    // reset mid-transaction: write parked in WAITB, read parked in FWD
    b_hang[0] = 1'b1; ar_stall[1] = 1'b1;
    @(negedge clk);
    s_awaddr = 32'h4000_0000; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h4000_1000; s_arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_arv", 64'(m_arvalid), 64'b010);
    check_eq("pre_rst_brdy", 64'(m_bready), 64'b001);
    #2;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_mvalid", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'd0);
    check_eq("mid_rst_s",      64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 64'd0);
    check_eq("mid_rst_mready", 64'({m_bready, m_rready}), 64'd0);
    check_eq("mid_rst_rdata",  64'(s_rdata), 64'd0);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    b_hang[0] = 1'b0; ar_stall[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_arready", 64'(s_arready), 64'd1);
    axw(32'h4000_0100, 32'h7777_0000, 4'h3, 0, lw, rw);
    check_eq("post_rst_wlat",  64'(lw), 64'd3);
    check_eq("post_rst_wresp", 64'(rw), 64'd0);
    check_eq("post_rst_strb",  64'(g_slv[0].last_wstrb), 64'h3);
    r_data[1] = 32'h0F0F_0F0F;
    axr(32'h4000_1004, 0, lr, dr, rr);
    check_eq("post_rst_rdata", 64'(dr), 64'h0F0F_0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
  end

endmodule
